instruction_fetch: RTL and testbench

//   Front-end stage feeding instructionDecode. Holds the PC, issues in-order word fetches to the

---
 rtl/instruction_fetch_if.sv | 50 +++++
 rtl/instruction_fetch.sv | 148 ++++++++++++++
 tb/tb_instruction_fetch.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/instruction_fetch_if.sv
// Fetch-stage bundle: imem request/response, execute redirect and decode handshake.
// FETCH_MISALIGN_TRAP_EN adds inst_fault alongside the decode handshake.
interface instruction_fetch_if;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        inst_fault;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output inst_valid, inst_data, inst_pc, inst_fault,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  inst_valid, inst_data, inst_pc, inst_fault,
        output inst_ready
    );
`else
    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_pc,
        output inst_valid, inst_data, inst_pc,
        input  inst_ready
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_pc,
        input  inst_valid, inst_data, inst_pc,
        output inst_ready
    );
`endif
endinterface

// File: rtl/instruction_fetch.sv
// In-order instruction fetch: PC, credit-limited imem requests, response FIFO, redirect flush.
// Optional FETCH_MISALIGN_TRAP_EN: misaligned redirect yields one fault entry and halts fetch.
module instruction_fetch #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned FIFO_DEPTH = 2
) (
    input logic clk,
    input logic rst,
    instruction_fetch_if.master bus
);
    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(FIFO_DEPTH);

    logic [31:0]      pc;
    logic [31:0]      rsp_pc;
    logic [31:0]      redirect_tgt;
    logic [31:0]      fifo_data [FIFO_DEPTH];
    logic [31:0]      fifo_pc   [FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] outstanding;
    logic [CNT_W-1:0] discard;

    logic        credit_ok;
    logic        req_valid;
    logic        req_fire;
    logic        rsp_drop;
    logic        rsp_push;
    logic        fifo_push;
    logic [31:0] push_data;
    logic [31:0] push_pc;
    logic        inst_valid;
    logic        pop;
    logic        fetch_halted;

    assign redirect_tgt = bus.redirect_pc & 32'hFFFF_FFFC;

`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fifo_fault [FIFO_DEPTH];
    logic        halted;
    logic        fault_pending;
    logic [31:0] fault_pc;
    logic        misaligned;
    logic        fault_push;

    assign misaligned   = bus.redirect_pc[1:0] != 2'b00;
    assign fetch_halted = halted;
    assign fault_push   = fault_pending & ~bus.redirect_valid;
    assign bus.inst_fault = fifo_fault[rd_ptr];
`else
    assign fetch_halted = 1'b0;
`endif

    assign credit_ok = ({1'b0, outstanding} + {1'b0, count}) < DEPTH_C;
    assign req_valid = ~rst & ~bus.redirect_valid & credit_ok & ~fetch_halted;
    assign req_fire  = req_valid & bus.imem_req_ready;
    assign rsp_drop  = bus.imem_rsp_valid & (discard != '0);
    assign rsp_push  = bus.imem_rsp_valid & (discard == '0) & ~bus.redirect_valid;
    assign inst_valid = (count != '0) & ~bus.redirect_valid;
    assign pop        = inst_valid & bus.inst_ready;

    always_comb begin
        fifo_push = rsp_push;
        push_data = bus.imem_rsp_data;
        push_pc   = rsp_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
        if (fault_push) begin
            fifo_push = 1'b1;
            push_data = 32'h0000_0013;
            push_pc   = fault_pc;
        end
`endif
    end

    assign bus.imem_req_valid = req_valid;
    assign bus.imem_req_addr  = pc;
    assign bus.inst_valid     = inst_valid;
    assign bus.inst_data      = fifo_data[rd_ptr];
    assign bus.inst_pc        = fifo_pc[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= RESET_PC;
            rsp_pc      <= RESET_PC;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
            outstanding <= '0;
            discard     <= '0;
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
                fifo_data[i] <= '0;
                fifo_pc[i]   <= '0;
`ifdef FETCH_MISALIGN_TRAP_EN
                fifo_fault[i] <= 1'b0;
`endif
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            halted        <= 1'b0;
            fault_pending <= 1'b0;
            fault_pc      <= '0;
`endif
        end else begin
            outstanding <= outstanding + CNT_W'(req_fire) - CNT_W'(bus.imem_rsp_valid);
            if (bus.redirect_valid) begin
                pc      <= redirect_tgt;
                rsp_pc  <= redirect_tgt;
                rd_ptr  <= '0;
                wr_ptr  <= '0;
                count   <= '0;
                // Every fetch still in flight after this edge belongs to the old stream;
                // earlier pending discards are already part of outstanding.
                discard <= outstanding - CNT_W'(bus.imem_rsp_valid);
`ifdef FETCH_MISALIGN_TRAP_EN
                halted        <= misaligned;
                fault_pending <= misaligned;
                fault_pc      <= bus.redirect_pc;
`endif
            end else begin
                if (req_fire) begin
                    pc <= pc + 32'd4;
                end
                if (rsp_drop) begin
                    discard <= discard - 1'b1;
                end
                if (rsp_push) begin
                    rsp_pc <= rsp_pc + 32'd4;
                end
                if (fifo_push) begin
                    fifo_data[wr_ptr] <= push_data;
                    fifo_pc[wr_ptr]   <= push_pc;
`ifdef FETCH_MISALIGN_TRAP_EN
                    fifo_fault[wr_ptr] <= fault_push;
`endif
                    wr_ptr <= wr_ptr + 1'b1;
                end
                if (pop) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + CNT_W'(fifo_push) - CNT_W'(pop);
`ifdef FETCH_MISALIGN_TRAP_EN
                fault_pending <= 1'b0;
`endif
            end
        end
    end
endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: directed redirects/backpressure with a
// variable-latency memory model; monitor pops expected {data, pc} on each decode handshake.
module tb_instruction_fetch;
    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    instruction_fetch_if bus ();

    instruction_fetch #(
        .RESET_PC   (32'h0000_0000),
        .FIFO_DEPTH (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    typedef struct {
        logic [31:0] addr;
        int unsigned due;
    } mreq_t;

    exp_t        exp_q [$];
    mreq_t       mq    [$];
    int unsigned tests   = 0;
    int unsigned failed  = 0;
    int unsigned fires   = 0;
    int unsigned cyc     = 0;
    int unsigned mem_lat = 1;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1F1F};
    endfunction

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_stream(input logic [31:0] base, input int unsigned n);
        for (int unsigned i = 0; i < n; i++) begin
            exp_q.push_back('{data: mem_word(base + 32'(4 * i)), pc: base + 32'(4 * i), fault: 1'b0});
        end
    endtask

    task automatic drain(input string name);
        int unsigned budget;
        budget = 0;
        bus.inst_ready = 1'b1;
        while (exp_q.size() != 0 && budget < 100) begin
            step();
            budget++;
        end
        bus.inst_ready = 1'b0;
        tests++;
        if (exp_q.size() != 0) begin
            failed++;
            $display("FAIL %s_timeout: got %0d entries left expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic redirect(input logic [31:0] target);
        bus.redirect_valid = 1'b1;
        bus.redirect_pc    = target;
        step();
        bus.redirect_valid = 1'b0;
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Memory model: responses exactly mem_lat cycles after acceptance, in order.
    initial begin
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                mq.delete();
                bus.imem_rsp_valid = 1'b0;
            end else begin
                if (mq.size() != 0 && mq[0].due == cyc + 1) begin
                    bus.imem_rsp_valid = 1'b1;
                    bus.imem_rsp_data  = mem_word(mq[0].addr);
                    void'(mq.pop_front());
                end else begin
                    bus.imem_rsp_valid = 1'b0;
                end
                if (bus.imem_req_valid && bus.imem_req_ready) begin
                    mq.push_back('{addr: bus.imem_req_addr, due: cyc + 1 + mem_lat});
                    fires++;
                end
            end
        end
    end

    // Monitor: compares every decode handshake against the scoreboard.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (bus.redirect_valid) begin
                    check32("valid_in_redirect", {31'b0, bus.inst_valid}, 32'd0);
                end
                if (bus.inst_valid && bus.inst_ready) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        failed++;
                        $display("FAIL unexpected_pop: got pc %h expected no instruction", bus.inst_pc);
                    end else begin
                        e = exp_q.pop_front();
                        check32("inst_pc", bus.inst_pc, e.pc);
                        check32("inst_data", bus.inst_data, e.data);
`ifdef FETCH_MISALIGN_TRAP_EN
                        check32("inst_fault", {31'b0, bus.inst_fault}, {31'b0, e.fault});
`endif
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned f0;
        rst                = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.inst_ready     = 1'b0;
        bus.imem_req_ready = 1'b1;
        repeat (3) step();

        check32("rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        check32("rst_req_addr", bus.imem_req_addr, 32'h0000_0000);
        check32("rst_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
        check32("rst_inst_pc", bus.inst_pc, 32'd0);
        check32("rst_inst_data", bus.inst_data, 32'd0);

        // Stream from reset: request at edge 1, response edge 2, valid after edge 2
        push_stream(32'h0, 8);
        bus.inst_ready = 1'b1;
        rst = 1'b0;
        #1;
        check32("first_req_valid", {31'b0, bus.imem_req_valid}, 32'd1);
        check32("first_req_addr", bus.imem_req_addr, 32'h0000_0000);
        step();
        check32("lat_valid_n1", {31'b0, bus.inst_valid}, 32'd0);
        step();
        check32("lat_valid_n2", {31'b0, bus.inst_valid}, 32'd1);
        check32("lat_pc_n2", bus.inst_pc, 32'h0000_0000);
        drain("stream0");

        // Decode stalled: exactly FIFO_DEPTH requests, then order preserved
        redirect(32'h40);
        f0 = fires;
        repeat (10) step();
        check32("stall_fires", fires - f0, 32'd2);
        check32("stall_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        push_stream(32'h40, 6);
        drain("stall");

        // Memory not ready: address holds, nothing accepted
        bus.imem_req_ready = 1'b0;
        redirect(32'h80);
        f0 = fires;
        for (int unsigned i = 0; i < 3; i++) begin
            check32("hold_addr", bus.imem_req_addr, 32'h80);
            step();
        end
        check32("hold_fires", fires - f0, 32'd0);
        bus.imem_req_ready = 1'b1;
        push_stream(32'h80, 4);
        drain("hold");

        // Redirect with one word buffered and one response landing on the redirect edge
        mem_lat = 2;
        repeat (5) step();
        redirect(32'hC0);
        repeat (3) step();
        check32("pre_redir_valid", {31'b0, bus.inst_valid}, 32'd1);
        check32("pre_redir_pc", bus.inst_pc, 32'hC0);
        check32("pre_redir_req", {31'b0, bus.imem_req_valid}, 32'd0);
        redirect(32'h100);
        push_stream(32'h100, 4);
        drain("redir");

        // Four back-to-back redirects with two fetches in flight
        repeat (5) step();
        redirect(32'h2F0);
        repeat (2) step();
        redirect(32'h300);
        redirect(32'h400);
        redirect(32'h500);
        redirect(32'h600);
        push_stream(32'h600, 5);
        drain("multi_redir");
        mem_lat = 1;

`ifdef FETCH_MISALIGN_TRAP_EN
        repeat (3) step();
        exp_q.push_back('{data: 32'h0000_0013, pc: 32'h102, fault: 1'b1});
        redirect(32'h102);
        f0 = fires;
        drain("fault");
        repeat (5) step();
        check32("fault_fires", fires - f0, 32'd0);
        check32("fault_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        redirect(32'h200);
        push_stream(32'h200, 4);
        drain("fault_resume");
`endif

        // Reset in mid-stream restarts from RESET_PC
        redirect(32'h700);
        push_stream(32'h700, 2);
        drain("pre_reset");
        repeat (2) step();
        rst = 1'b1;
        repeat (2) step();
        check32("mid_rst_inst_valid", {31'b0, bus.inst_valid}, 32'd0);
        check32("mid_rst_req_valid", {31'b0, bus.imem_req_valid}, 32'd0);
        check32("mid_rst_addr", bus.imem_req_addr, 32'h0);
        push_stream(32'h0, 4);
        rst = 1'b0;
        drain("post_reset");

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
